// File: rtl/cmd_pkg.sv
// Shared constants and state encodings for the serial command receiver.
// Imported by the byte receiver and the frame assembler.
package cmd_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         OPC_W    = 3;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        ASM_HDR = 2'd0,
        ASM_OPC = 2'd1,
        ASM_OPA = 2'd2,
        ASM_OPB = 2'd3
    } asm_state_t;

    // An opcode byte is legal only when everything above the opcode field is zero.
    function automatic logic is_opc_byte(input logic [7:0] b);
        return (b[7:OPC_W] == 5'd0);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling,
// one-cycle byte strobe and frame-error pulse.
module uart_rx
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic             rx_s;
    logic             fall_s;
    logic             tick_s;
    logic             dv_s;
    logic             fe_s;
    rx_state_t        state_r;
    rx_state_t        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       data_out_r;
    logic             data_valid_r;
    logic             frame_error_r;
    logic             busy_r;

    assign rx_s   = sync2_r;
    assign fall_s = prev_r & ~rx_s;

    // Synchroniser and edge history; all idle high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Sample point: half a bit into the start bit, then every full bit.
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            RX_START:         tick_s = (cnt_r == HALF_LAST);
            RX_DATA, RX_STOP: tick_s = (cnt_r == BIT_LAST);
            default:          tick_s = 1'b0;
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Receiver next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) state_s = RX_START;
                else        state_s = RX_IDLE;
            end
            RX_START: begin
                if (tick_s) state_s = rx_s ? RX_IDLE : RX_DATA;
                else        state_s = RX_START;
            end
            RX_DATA: begin
                if (tick_s && (bit_idx_r == 3'd7)) state_s = RX_STOP;
                else                               state_s = RX_DATA;
            end
            RX_STOP: begin
                if (tick_s) state_s = RX_IDLE;
                else        state_s = RX_STOP;
            end
            default: state_s = RX_IDLE;
        endcase
    end

    // Stop-bit outcome.
    always_comb begin
        dv_s = 1'b0;
        fe_s = 1'b0;
        if ((state_r == RX_STOP) && tick_s) begin
            dv_s = rx_s;
            fe_s = ~rx_s;
        end else begin
            dv_s = 1'b0;
            fe_s = 1'b0;
        end
    end

    // Bit timer, shift register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r         <= '0;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            data_out_r    <= 8'h00;
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if ((state_r == RX_IDLE) || (state_s != state_r) || tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (state_r != RX_DATA) begin
                bit_idx_r <= 3'd0;
            end else if (tick_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
                shift_r   <= {rx_s, shift_r[7:1]};
            end
            if (dv_s) begin
                data_out_r <= shift_r;
            end
            data_valid_r  <= dv_s;
            frame_error_r <= fe_s;
            busy_r        <= (state_s != RX_IDLE);
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign frame_error = frame_error_r;
    assign busy        = busy_r;

endmodule

// File: rtl/cmd_rx.sv
// Command receiver: assembles A5/opcode/a/b byte frames from uart_rx,
// enforces an inter-byte timeout and presents commands with valid/ready.
module cmd_rx
    import cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [OPC_W-1:0] cmd_opcode,
    output logic [7:0]       cmd_a,
    output logic [7:0]       cmd_b,
    output logic             frame_error,
    output logic             cmd_error,
    output logic             overrun,
    output logic             rx_busy
);

    localparam int              TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int              TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYCLES - 1);

    logic [7:0]       byte_s;
    logic             byte_valid_s;
    logic             rx_ferr_s;
    asm_state_t       asm_state_r;
    asm_state_t       asm_next_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic             timeout_s;
    logic             hdr_err_s;
    logic             opc_err_s;
    logic             complete_s;
    logic [OPC_W-1:0] opc_tmp_r;
    logic [7:0]       a_tmp_r;
    logic             cmd_valid_r;
    logic [OPC_W-1:0] cmd_opcode_r;
    logic [7:0]       cmd_a_r;
    logic [7:0]       cmd_b_r;
    logic             cmd_error_r;
    logic             overrun_r;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data_out    (byte_s),
        .data_valid  (byte_valid_s),
        .frame_error (rx_ferr_s),
        .busy        (rx_busy)
    );

    assign timeout_s = (asm_state_r != ASM_HDR) && !byte_valid_s && (to_cnt_r == TO_LAST);

    // Cycles since the last byte strobe while a frame is partially assembled.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if ((asm_state_r == ASM_HDR) || byte_valid_s || timeout_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end
    end

    // Assembler state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            asm_state_r <= ASM_HDR;
        end else begin
            asm_state_r <= asm_next_s;
        end
    end

    // Assembler next-state logic; a framing error abandons any partial frame.
    always_comb begin
        asm_next_s = asm_state_r;
        if (rx_ferr_s) begin
            asm_next_s = ASM_HDR;
        end else if (byte_valid_s) begin
            case (asm_state_r)
                ASM_HDR: asm_next_s = (byte_s == HDR_BYTE) ? ASM_OPC : ASM_HDR;
                ASM_OPC: asm_next_s = is_opc_byte(byte_s) ? ASM_OPA : ASM_HDR;
                ASM_OPA: asm_next_s = ASM_OPB;
                ASM_OPB: asm_next_s = ASM_HDR;
                default: asm_next_s = ASM_HDR;
            endcase
        end else if (timeout_s) begin
            asm_next_s = ASM_HDR;
        end else begin
            asm_next_s = asm_state_r;
        end
    end

    // Assembler per-byte outcomes.
    always_comb begin
        hdr_err_s  = 1'b0;
        opc_err_s  = 1'b0;
        complete_s = 1'b0;
        if (byte_valid_s) begin
            case (asm_state_r)
                ASM_HDR: hdr_err_s  = (byte_s != HDR_BYTE);
                ASM_OPC: opc_err_s  = ~is_opc_byte(byte_s);
                ASM_OPB: complete_s = 1'b1;
                default: complete_s = 1'b0;
            endcase
        end else begin
            complete_s = 1'b0;
        end
    end

    // Partial frame fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            opc_tmp_r <= '0;
            a_tmp_r   <= 8'h00;
        end else if (byte_valid_s && (asm_state_r == ASM_OPC) && is_opc_byte(byte_s)) begin
            opc_tmp_r <= byte_s[OPC_W-1:0];
        end else if (byte_valid_s && (asm_state_r == ASM_OPA)) begin
            a_tmp_r <= byte_s;
        end
    end

    // Output handshake: a completion in an accept cycle replaces the old command.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_valid_r  <= 1'b0;
            cmd_opcode_r <= '0;
            cmd_a_r      <= 8'h00;
            cmd_b_r      <= 8'h00;
            cmd_error_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            cmd_error_r <= hdr_err_s | opc_err_s | timeout_s;
            overrun_r   <= 1'b0;
            if (complete_s && (!cmd_valid_r || cmd_ready)) begin
                cmd_valid_r  <= 1'b1;
                cmd_opcode_r <= opc_tmp_r;
                cmd_a_r      <= a_tmp_r;
                cmd_b_r      <= byte_s;
            end else if (complete_s) begin
                overrun_r <= 1'b1;
            end else if (cmd_valid_r && cmd_ready) begin
                cmd_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_valid   = cmd_valid_r;
    assign cmd_opcode  = cmd_opcode_r;
    assign cmd_a       = cmd_a_r;
    assign cmd_b       = cmd_b_r;
    assign cmd_error   = cmd_error_r;
    assign overrun     = overrun_r;
    assign frame_error = rx_ferr_s;

endmodule

// File: doc/cmd_rx.md
CMD_RX -- requirements
Module: cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; legal range 4 or more.
REQ-002 Parameter TIMEOUT_BITS, default 20, idle bit-times between frame bytes before the assembler aborts.
REQ-003 Port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx  input  1  asynchronous UART serial line, idle high.
REQ-006 Port cmd_ready  input  1  consumer (ALU/TX sequencer) accepts the pending command.
REQ-007 Port cmd_valid  output  1  a decoded command is pending.
REQ-008 Port cmd_opcode  output  3  decoded ALU opcode.
REQ-009 Port cmd_a  output  8  decoded operand a.
REQ-010 Port cmd_b  output  8  decoded operand b.
REQ-011 Port frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 Port cmd_error  output  1  one-cycle pulse: bad header, bad opcode byte, or inter-byte timeout.
REQ-013 Port overrun  output  1  one-cycle pulse: frame completed while cmd_valid was still pending.
REQ-014 Port rx_busy  output  1  high from start-bit detect until the stop-bit sample.

Function
REQ-015 rx SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value.
REQ-016 Line format SHALL be 8N1, LSB first.
REQ-017 Byte receiver states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE->START SHALL occur on a synchronised high-to-low transition.
REQ-019 START SHALL resample rx at CLKS_PER_BIT/2 cycles: low goes to DATA; high is a false start, returns to IDLE, and raises no error.
REQ-020 DATA SHALL sample each bit every CLKS_PER_BIT cycles after the start mid-point; 3-bit index, 8 bits, then STOP.
REQ-021 STOP SHALL sample one bit-time later: high delivers the byte (one-cycle byte strobe); low drops the byte, pulses frame_error and resets the assembler to HDR. Either way the receiver returns to IDLE.
REQ-022 Frame assembler states SHALL be HDR, OPC, OPA, OPB, each consuming one delivered byte.
REQ-023 HDR SHALL require byte 0xA5; any other byte pulses cmd_error and stays in HDR.
REQ-024 OPC SHALL require byte[7:3]==0 and store byte[2:0]; otherwise it pulses cmd_error and goes to HDR.
REQ-025 OPA SHALL store a; OPB SHALL store b and complete the frame, then return to HDR.
REQ-026 In OPC/OPA/OPB, no delivered byte within TIMEOUT_BITS*CLKS_PER_BIT cycles after the previous byte strobe SHALL pulse cmd_error and return to HDR.
REQ-027 On completion with cmd_valid low, cmd_opcode/cmd_a/cmd_b SHALL load and cmd_valid SHALL rise on the cycle after the final byte strobe (latency 1).
REQ-028 cmd_valid and the cmd_* outputs SHALL hold stable until a cycle with cmd_valid&&cmd_ready; cmd_valid falls on the next edge.
REQ-029 Completion on the same cycle as cmd_valid&&cmd_ready SHALL be accepted: new data loads and cmd_valid stays high, with no overrun.
REQ-030 Completion while cmd_valid is high and cmd_ready is low SHALL drop the new frame, keep the old outputs, and pulse overrun.
REQ-031 Error pulses SHALL be exactly one cycle; simultaneous errors MAY assert together.

Reset
REQ-032 Reset SHALL force both FSMs to IDLE/HDR and clear all counters.
REQ-033 Reset SHALL drive cmd_valid, frame_error, cmd_error, overrun and rx_busy to 0, and cmd_opcode, cmd_a and cmd_b to 0.
REQ-034 Synchroniser flops SHALL reset to 1 (line idle).
REQ-035 Reset mid-byte or mid-frame SHALL discard partial data; reception restarts at the next falling edge after reset deasserts.

Structure
REQ-036 Shared package cmd_pkg SHALL hold the header constant 0xA5, the opcode width (3), and both state encodings.
REQ-037 The byte receiver SHALL be sub-module uart_rx (ports clock, reset, rx, data_out[7:0], data_valid, frame_error, busy); cmd_rx holds the assembler, timeout counter and output handshake.

Verification (bench CLKS_PER_BIT=16, TIMEOUT_BITS=20)
REQ-038 Send A5,03,12,34 with cmd_ready=0 -> cmd_valid=1, opcode=3, a=0x12, b=0x34, held stable; assert cmd_ready one cycle -> cmd_valid=0 next cycle.
REQ-039 Send 0x55 with stop bit forced low -> frame_error one pulse, no cmd_valid; then a valid frame A5,01,FF,01 -> opcode=1, a=0xFF, b=0x01.
REQ-040 Send A5,08 -> cmd_error pulse at the second byte strobe; then A5,02,07,09 -> opcode=2, a=7, b=9.
REQ-041 Send A5,04,10, then idle 21 bit-times -> cmd_error pulse, no cmd_valid; the next full frame decodes correctly.
REQ-042 Two back-to-back frames (A5,00,01,02 then A5,05,03,04) with cmd_ready=0 -> overrun pulse, outputs stay 00/01/02; repeat with cmd_ready=1 on the second frame's completion cycle -> outputs 05/03/04, no overrun.
REQ-043 8-cycle low glitch on idle rx -> no byte, no error, rx_busy high briefly; reset asserted mid-DATA -> all outputs 0, next frame decodes.
